// File: rtl/io_mmio_pkg.sv
// Shared I/O window constants and STATUS layout for the MMIO controller and the datapath load mux.
package io_mmio_pkg;

   localparam int unsigned ADDR_W = 32;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned BYTE_W = 8;
   localparam int unsigned OFF_W  = 28;

   localparam logic [3:0] IO_WINDOW = 4'h8;

   localparam logic [OFF_W-1:0] STATUS    = 28'h000_0000;
   localparam logic [OFF_W-1:0] RX_DATA   = 28'h000_0004;
   localparam logic [OFF_W-1:0] TX_DATA   = 28'h000_0008;
   localparam logic [OFF_W-1:0] CYCLE     = 28'h000_0010;
   localparam logic [OFF_W-1:0] CYCLE_CLR = 28'h000_0018;

   localparam int unsigned ST_TX_FREE = 0;
   localparam int unsigned ST_RX_NE   = 1;
   localparam int unsigned ST_OVR     = 2;

   // Field order matches the ST_* bit positions (LSB last).
   typedef struct packed {
      logic ovr;
      logic rx_ne;
      logic tx_free;
   } status_t;

   function automatic logic [DATA_W-1:0] status_word(input status_t s);
      return DATA_W'(s);
   endfunction

endpackage

// File: rtl/io_mmio_if.sv
// Datapath data-port and UART handshake bundle seen by the MMIO controller.
interface io_mmio_if;
   import io_mmio_pkg::*;

   logic              stall;
   logic [ADDR_W-1:0] addr;
   logic [3:0]        we;
   logic              re;
   logic [DATA_W-1:0] din;
   logic [DATA_W-1:0] dout;
   logic              io_sel;
   logic [BYTE_W-1:0] uart_tx_data;
   logic              uart_tx_valid;
   logic              uart_tx_ready;
   logic [BYTE_W-1:0] uart_rx_data;
   logic              uart_rx_valid;
   logic              uart_rx_ready;

   modport slave (
      input  stall, addr, we, re, din, uart_tx_ready, uart_rx_data, uart_rx_valid,
      output dout, io_sel, uart_tx_data, uart_tx_valid, uart_rx_ready
   );

   modport master (
      output stall, addr, we, re, din, uart_tx_ready, uart_rx_data, uart_rx_valid,
      input  dout, io_sel, uart_tx_data, uart_tx_valid, uart_rx_ready
   );

endinterface

// File: rtl/io_rx_fifo.sv
// Synchronous FIFO for received UART bytes; extra pointer MSB separates full from empty.
module io_rx_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_din,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_head_c,
   output logic             o_full_c,
   output logic             o_empty_c
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned PW = AW + 1;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PW-1:0]    r_wr;
   logic [PW-1:0]    r_rd;
   logic             w_do_push;
   logic             w_do_pop;

   assign o_empty_c = (r_wr == r_rd);
   assign o_full_c  = (r_wr[AW-1:0] == r_rd[AW-1:0]) && (r_wr[AW] != r_rd[AW]);
   assign o_head_c  = r_mem[r_rd[AW-1:0]];
   assign w_do_push = i_push & ~o_full_c;
   assign w_do_pop  = i_pop & ~o_empty_c;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr <= '0;
         r_rd <= '0;
      end else begin
         if (w_do_push) r_wr <= r_wr + PW'(1);
         if (w_do_pop)  r_rd <= r_rd + PW'(1);
      end
   end

   // Storage needs no reset: contents are only visible through valid pointers.
   always_ff @(posedge clk) begin
      if (w_do_push) r_mem[r_wr[AW-1:0]] <= i_din;
   end

endmodule

// File: rtl/io_mmio_ctrl.sv
// MMIO controller: decodes the 0x8xxxxxxx window, sequences UART TX/RX and keeps a cycle counter.
module io_mmio_ctrl
   import io_mmio_pkg::*;
#(
   parameter int unsigned RX_DEPTH = 4
) (
   input logic       clk,
   input logic       rst,
   io_mmio_if.slave  bus
);

   logic [OFF_W-1:0]  w_off;
   logic              w_live;
   logic              w_rd;
   logic              w_wr;
   logic              w_tx_wr;
   logic              w_tx_hs;
   logic              w_st_rd;
   logic              w_clr;
   logic              w_pop;
   logic              w_push;
   logic [BYTE_W-1:0] w_rx_head;
   logic              w_rx_full;
   logic              w_rx_empty;
   logic [DATA_W-1:0] w_cycle_nxt;
   logic [DATA_W-1:0] w_rdata;
   status_t           w_status;

   logic [DATA_W-1:0] r_dout;
   logic [BYTE_W-1:0] r_tx_data;
   logic              r_tx_full;
   logic              r_ovr;
   logic [DATA_W-1:0] r_cycle;

   assign w_off       = bus.addr[OFF_W-1:0];
   assign bus.io_sel  = (bus.addr[ADDR_W-1:OFF_W] == IO_WINDOW);
   assign w_live      = bus.io_sel & ~bus.stall & (bus.re | (|bus.we));
   assign w_rd        = w_live & bus.re;
   assign w_wr        = w_live & (|bus.we);
   assign w_tx_wr     = w_wr & bus.we[0] & (w_off == TX_DATA);
   assign w_clr       = w_wr & (w_off == CYCLE_CLR);
   assign w_st_rd     = w_rd & (w_off == STATUS);
   assign w_tx_hs     = r_tx_full & bus.uart_tx_ready;
   assign w_pop       = w_rd & (w_off == RX_DATA) & ~w_rx_empty;
   assign w_push      = bus.uart_rx_valid & ~w_rx_full;
   assign w_cycle_nxt = r_cycle + DATA_W'(1);

   assign bus.dout          = r_dout;
   assign bus.uart_tx_data  = r_tx_data;
   assign bus.uart_tx_valid = r_tx_full;
   assign bus.uart_rx_ready = ~w_rx_full;

   io_rx_fifo #(
      .DEPTH (RX_DEPTH),
      .WIDTH (BYTE_W)
   ) u_rx_fifo (
      .clk       (clk),
      .rst       (rst),
      .i_push    (w_push),
      .i_din     (bus.uart_rx_data),
      .i_pop     (w_pop),
      .o_head_c  (w_rx_head),
      .o_full_c  (w_rx_full),
      .o_empty_c (w_rx_empty)
   );

   // Read mux; STATUS shows pre-edge state, CYCLE shows the count the sampling edge produces.
   always_comb begin
      w_rdata  = '0;
      w_status = '{ovr: r_ovr, rx_ne: ~w_rx_empty, tx_free: ~r_tx_full};
      case (w_off)
         STATUS:  w_rdata = status_word(w_status);
         RX_DATA: w_rdata = w_rx_empty ? '0 : DATA_W'(w_rx_head);
         CYCLE:   w_rdata = w_cycle_nxt;
         default: w_rdata = '0;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_dout <= '0;
      end else if (bus.re && !bus.stall) begin
         r_dout <= bus.io_sel ? w_rdata : '0;
      end
   end

   // A write landing on a handshake edge refills the holding register; otherwise a full one overruns.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_tx_data <= '0;
         r_tx_full <= 1'b0;
         r_ovr     <= 1'b0;
      end else begin
         if (w_tx_wr && (!r_tx_full || w_tx_hs)) begin
            r_tx_data <= bus.din[BYTE_W-1:0];
            r_tx_full <= 1'b1;
         end else if (w_tx_hs) begin
            r_tx_full <= 1'b0;
         end
         if (w_tx_wr && r_tx_full && !w_tx_hs) r_ovr <= 1'b1;
         else if (w_st_rd)                     r_ovr <= 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)        r_cycle <= '0;
      else if (w_clr) r_cycle <= '0;
      else            r_cycle <= w_cycle_nxt;
   end

endmodule

// File: doc/io_mmio_ctrl.md
# io_mmio_ctrl

Memory-mapped I/O controller sitting between the CPU datapath's data-memory port and the UART. It decodes the I/O address window and sequences UART transmit and receive through valid/ready handshakes, buffering received bytes in a small FIFO. It also provides a free-running cycle counter for software timing. The datapath steers loads and stores here instead of to data memory whenever `io_sel` is high.

## Interface
Parameters:
- `RX_DEPTH`, 4: RX FIFO entries; power of two, at least 2.

Ports:
- `clk`  in  1  sole clock.
- `rst`  in  1  asynchronous, active-high reset.
- `stall`  in  1  pipeline stall; while high, all requests are ignored.
- `addr`  in  32  byte address from the datapath's data port.
- `we`  in  4  byte write enables.
- `re`  in  1  read request.
- `din`  in  32  store data.
- `dout`  out  32  registered load data.
- `io_sel`  out  1  combinational; high when `addr[31:28]==4'h8`.
- `uart_tx_data`  out  8  byte to transmit.
- `uart_tx_valid`  out  1  TX byte pending.
- `uart_tx_ready`  in  1  UART accepts the byte.
- `uart_rx_data`  in  8  received byte.
- `uart_rx_valid`  in  1  UART has a byte.
- `uart_rx_ready`  out  1  controller accepts the byte; equals RX FIFO not full.

## Operation
- A request is live when `io_sel & !stall` and `re` or `|we` is high.
- Register map (word offsets within the window):
  - `0x00` STATUS (read): bit0 = TX free (`!tx_full`); bit1 = RX nonempty; bit2 = TX overrun (sticky). All other bits read 0. A read clears bit2.
  - `0x04` RX_DATA (read): `{24'b0, head byte}` and pops the FIFO. When the FIFO is empty, a read returns 0 and nothing changes.
  - `0x08` TX_DATA (write, needs `we[0]`): loads `din[7:0]` into the single-entry holding register and sets `tx_full`.
  - `0x10` CYCLE (read): 32-bit counter. It increments every cycle, ignoring `stall`, and wraps at 2^32.
  - `0x18` CYCLE_CLR (write, any `we`): zeroes the counter. On the following cycle CYCLE reads 1.
- Unmapped offsets: reads return 0, writes are no-ops. Reads outside the window (`io_sel` low) drive `dout` = 0.
- TX handshake:
  - `uart_tx_valid = tx_full`.
  - When `valid & ready` on an edge, `tx_full` clears.
  - A TX_DATA write while `tx_full` is high and no handshake occurs that cycle drops the byte and sets overrun.
  - A write in the same cycle as a handshake is accepted; `tx_full` stays 1 with the new byte.
- RX handshake:
  - A byte is pushed when `uart_rx_valid & uart_rx_ready`.
  - When the FIFO is full, `uart_rx_ready` is low and the UART holds its byte.
  - A push and a pop in the same cycle on a nonempty FIFO leave the count unchanged.
  - A pop on an empty FIFO in the same cycle as a push returns 0; the pushed byte stays.
- Reset (async): `dout`=0, `tx_full`=0, overrun=0, FIFO empty (`uart_rx_ready`=1), `uart_tx_valid`=0, `uart_tx_data`=0, counter=0. Reset asserted mid-handshake discards the pending TX byte and all buffered RX bytes.

## Timing
- Read latency is 1 cycle: `dout` is registered on the edge that samples `re`. This matches block-RAM load timing.
- `dout` holds its value while `stall` is high.
- Pops, pushes, clears and writes all take effect on the sampling edge.
- STATUS reflects state before that edge's updates. A status read in the same cycle as a push shows the pre-push value.
- TX write to `uart_tx_valid` high: 1 cycle.
- RX byte accepted to STATUS bit1 visible: readable on the next request.
- FIFO pointers are `$clog2(RX_DEPTH)+1` bits wide; the MSB distinguishes full from empty, and pointers wrap naturally.

## Structure
- Shared package `io_mmio_pkg` holds the window nibble `4'h8`, the offset constants (`STATUS`, `RX_DATA`, `TX_DATA`, `CYCLE`, `CYCLE_CLR`) and the STATUS bit positions. The datapath's load mux uses the same package.
- Sub-module `io_rx_fifo`: parameterized synchronous FIFO with push/pop, full/empty and head-byte output, using async reset.
- The decode, TX holding register, overrun flag, counter and read mux live in the top level.

## Test plan
- Reset mid-operation: with `tx_full`=1 and 2 RX bytes buffered, pulse `rst` -> the next cycle shows `uart_tx_valid`=0, STATUS=0x1, `uart_rx_ready`=1.
- TX write: write `0x41` to `0x80000008` with `uart_tx_ready`=0 -> `uart_tx_valid`=1 and `uart_tx_data`=0x41 next cycle. Write `0x42` -> STATUS reads 0x4 (overrun set, TX not free), then the next STATUS read shows bit2 clear.
- RX fill: push 0x10..0x14 with `RX_DEPTH`=4 -> `uart_rx_ready` goes low after the 4th byte and 0x14 is held. Four RX_DATA reads return 0x10..0x13, with 0x14 accepted after the first pop.
- Simultaneous RX: push 0x55 while popping a FIFO holding one byte 0xAA -> `dout`=0xAA, and the next read returns 0x55.
- Stall: issue an RX_DATA read with `stall`=1 -> no pop and `dout` unchanged.
- Counter: write CYCLE_CLR, then read CYCLE 3 cycles later -> `dout`=3. Preload the counter to 0xFFFFFFFF -> it wraps to 0.
